// File: rtl/arb4_sched.sv
// Four-requester arbiter for one shared resource: registered one-hot grant, hold timeout, one-cycle gap.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed priority 3>2>1>0.
module arb4_sched #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int unsigned LIMIT = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam logic [CW-1:0] CNT_SAT = '1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_id_q, last_id_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    win_id_c;
  logic          any_req_c;
  logic          owner_req_c;
  logic          limit_hit_c;
  logic          release_c;

`ifdef ARB_RR_EN
  logic [1:0]    rr_idx;
  logic          rr_found;
`endif

  // Winner selection for the current arbitration cycle
  always_comb begin
    win_id_c  = 2'd0;
    any_req_c = |req;
`ifdef ARB_RR_EN
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = last_id_q + 2'(k + 1);
      if (!rr_found && req[rr_idx]) begin
        win_id_c = rr_idx;
        rr_found = 1'b1;
      end
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (req[k]) win_id_c = 2'(k);
    end
`endif
  end

  assign owner_req_c = req[gnt_id_q];
  assign limit_hit_c = (HOLD_MAX != 0) && (cnt_q == CW'(LIMIT));
  assign release_c   = done || !owner_req_c || limit_hit_c;

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_id_q <= 2'd3;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_GAP: state_d = any_req_c ? S_BUSY : S_IDLE;
      S_BUSY:        state_d = release_c ? S_GAP : S_BUSY;
      default:       state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_GAP: begin
        if (any_req_c) begin
          gnt_d     = 4'(4'b0001 << win_id_c);
          gnt_id_d  = win_id_c;
          busy_d    = 1'b1;
          cnt_d     = '0;
          last_id_d = win_id_c;
        end else begin
          gnt_d  = 4'b0000;
          busy_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (release_c) begin
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          cnt_d     = '0;
          // Pulse only when the hold limit alone forced the release
          timeout_d = limit_hit_c && !done && owner_req_c;
        end else if (!((HOLD_MAX == 0) && (cnt_q == CNT_SAT))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb4_sched.sv
// Bench for arb4_sched (HOLD_MAX=4): vector table through a scoreboard queue, plus timeout,
// invariant and (with ARB_RR_EN) round-robin sequences.
module tb_arb4_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  arb4_sched #(.HOLD_MAX(4), .CW(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       chk_id;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                              input logic [3:0] g, input logic [1:0] id, input logic ci,
                              input logic b, input logic t);
    vec_t v;
    v.rst_n      = r;
    v.req        = rq;
    v.done       = d;
    v.exp.gnt    = g;
    v.exp.id     = id;
    v.exp.chk_id = ci;
    v.exp.busy   = b;
    v.exp.to     = t;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    logic ok;
    e = sb.pop_front();
    checks++;
    ok = (gnt === e.gnt) && (busy === e.busy) && (timeout === e.to) &&
         (!e.chk_id || (gnt_id === e.id));
    if (!ok) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
               name, gnt, gnt_id, busy, timeout, e.gnt, e.id, e.busy, e.to);
    end
  endtask

  task automatic apply(input logic r, input logic [3:0] rq, input logic d, input exp_t e,
                       input string name);
    rst_n = r;
    req   = rq;
    done  = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  task automatic check_val(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id, input logic b,
                              input logic t);
    exp_t e;
    e.gnt = g; e.id = id; e.chk_id = b; e.busy = b; e.to = t;
    return e;
  endfunction

  initial begin
    int n;
    logic [3:0] prev_gnt;
    rst_n = 1'b0;
    req   = 4'h0;
    done  = 1'b0;
    #2;

    //  rst  req    done  gnt    id ci busy to
    add(0, 4'hF, 0, 4'b0000, 0, 1, 0, 0);
    add(0, 4'hF, 0, 4'b0000, 0, 1, 0, 0);
    add(1, 4'h6, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h6, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h2, 0, 4'b0010, 1, 1, 1, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0000, 0, 0, 0, 1);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h1, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h8, 0, 4'b1000, 3, 1, 1, 0);
    add(1, 4'h8, 0, 4'b1000, 3, 1, 1, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h9, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'h9, 1, 4'b0000, 0, 0, 0, 0);
    add(1, 4'h9, 0, 4'b1000, 3, 1, 1, 0);
    add(0, 4'h9, 0, 4'b0000, 0, 1, 0, 0);
    add(1, 4'h9, 0, 4'b1000, 3, 1, 1, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 0, 0);

`ifndef ARB_RR_EN
    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].req, vecs[i].done, vecs[i].exp, $sformatf("vec%0d", i));
    end
`else
    // Round-robin: all requesting, done each grant -> order 0,1,2,3,0
    apply(0, 4'hF, 0, mk(4'b0000, 0, 0, 0), "rr_rst");
    apply(1, 4'hF, 0, mk(4'b0001, 0, 1, 0), "rr_g0");
    apply(1, 4'hF, 1, mk(4'b0000, 0, 0, 0), "rr_gap0");
    apply(1, 4'hF, 0, mk(4'b0010, 1, 1, 0), "rr_g1");
    apply(1, 4'hF, 1, mk(4'b0000, 0, 0, 0), "rr_gap1");
    apply(1, 4'hF, 0, mk(4'b0100, 2, 1, 0), "rr_g2");
    apply(1, 4'hF, 1, mk(4'b0000, 0, 0, 0), "rr_gap2");
    apply(1, 4'hF, 0, mk(4'b1000, 3, 1, 0), "rr_g3");
    apply(1, 4'hF, 1, mk(4'b0000, 0, 0, 0), "rr_gap3");
    apply(1, 4'hF, 0, mk(4'b0001, 0, 1, 0), "rr_g0b");
`endif

    // Hold-limit sequence: single requester held, never done
    apply(0, 4'h0, 0, mk(4'b0000, 0, 0, 0), "to_rst");
    rst_n = 1'b1;
    req   = 4'b0001;
    done  = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (gnt != 4'b0001 && n < 20);
    check_val("to_latency", n, 1);
    n = 0;
    while (gnt == 4'b0001 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check_val("to_hold_cycles", n, 4);
    check_val("to_pulse", int'(timeout), 1);
    check_val("to_gap_gnt", int'(gnt), 0);
    @(posedge clk);
    #1;
    check_val("to_regrant", int'(gnt), 1);
    check_val("to_cleared", int'(timeout), 0);

    // Random traffic: one-hot grant, busy tracks grant, a zero cycle between grants
    prev_gnt = gnt;
    for (int c = 0; c < 300; c++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
      checks++;
      if ($countones(gnt) > 1 || busy != (gnt != 4'b0000) ||
          (prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt)) begin
        errors++;
        $display("FAIL inv%0d: got gnt=%b prev=%b busy=%b, want one-hot/gap-separated grant",
                 c, gnt, prev_gnt, busy);
      end
      prev_gnt = gnt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
